// File: rtl/soc_pio_pkg.sv
// Shared constants for the SoC parallel I/O slaves: register map and edge-capture polarity.
package soc_pio_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchronizer, per-bit edge detector and post-reset event suppression.
module pio_sync_edge
  import soc_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned EDGE_TYPE   = EDGE_FALLING,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] event_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  raw;

  // Stage 0 takes the raw pin; the last stage is the synchronized value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= sync_out;
      if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Levels present at reset ripple through the chain as fake edges until the counter saturates.
  always_comb begin
    rise = sync_out & ~prev_q;
    fall = ~sync_out & prev_q;
    raw  = rise | fall;
    if (EDGE_TYPE == EDGE_RISING) begin
      raw = rise;
    end else if (EDGE_TYPE == EDGE_FALLING) begin
      raw = fall;
    end
    event_c = (cnt_q == CNT_MAX) ? raw : '0;
  end

endmodule

// File: rtl/avalon_input_pio_irq.sv
// Avalon-MM input PIO: synchronized DATA, sticky EDGECAPTURE, IRQ_MASK and a registered level irq.
module avalon_input_pio_irq
  import soc_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned EDGE_TYPE   = EDGE_FALLING,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [BUS_W-1:0]  writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [BUS_W-1:0]  readdata,
  output logic              irq
);

  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] event_c;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [BUS_W-1:0] readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_mask;
  logic             wr_edge;
  logic [WIDTH-1:0] clr_bits;
  logic             unused_wdata;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync_out (sync_out),
    .event_c  (event_c)
  );

  // Write data above WIDTH has no destination.
  assign unused_wdata = ^writedata;

  // A new event on a bit wins over a simultaneous write-1-clear so no edge is lost.
  always_comb begin
    mask_d     = mask_q;
    readdata_d = '0;
    wr_mask    = chipselect & ~write_n & (address == ADDR_MASK);
    wr_edge    = chipselect & ~write_n & (address == ADDR_EDGE);
    clr_bits   = wr_edge ? writedata[WIDTH-1:0] : '0;
    edge_d     = (edge_q & ~clr_bits) | event_c;
    irq_d      = |(edge_q & mask_q);
    if (wr_mask) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (chipselect) begin
      case (address)
        ADDR_DATA: readdata_d = BUS_W'(sync_out);
        ADDR_MASK: readdata_d = BUS_W'(mask_q);
        ADDR_EDGE: readdata_d = BUS_W'(edge_q);
        default:   readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
